match_ctrl: RTL and testbench

Pong match controller, upstream of the seven-segment match timer. It sequences a match through idle, serve, rally and game-over, and counts goals reported by the ball logic. It decodes each player's score to seven-segment patterns. It also drives the timer's active-low reset, so match time is held at zero until play starts and is cleared again when the match ends.

---
 rtl/match_ctrl.sv | 165 ++++++++++++++++
 tb/tb_match_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/match_ctrl.sv
// Pong match controller: idle/serve/play/over sequencing, scoring, 7-seg decode.
// Optional winner-digit blink in OVER when MATCH_CTRL_BLINK_EN is defined.
module match_ctrl #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 50000000,
  parameter int BLINK_HALF  = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_n,
  input  logic       goal_left,
  input  logic       goal_right,
  output logic       ball_release,
  output logic       timer_reset,
  output logic [6:0] seg_score_left,
  output logic [6:0] seg_score_right,
  output logic [1:0] winner
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam int CW = $clog2(SERVE_DELAY + 1);
  localparam logic [CW-1:0] SD_LAST = CW'(SERVE_DELAY - 1);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  logic [1:0]    r_state;
  logic [3:0]    r_score_l;
  logic [3:0]    r_score_r;
  logic [1:0]    r_winner;
  logic [CW-1:0] r_cnt;
  logic          r_release;
  logic          r_trst;
  logic          r_start_prev;
  logic          r_gl_prev;
  logic          r_gr_prev;

  logic       w_ev_start;
  logic       w_ev_gl;
  logic       w_ev_gr;
  logic [3:0] w_nxt_l;
  logic [3:0] w_nxt_r;
  logic       w_win_l;
  logic       w_win_r;
  logic [6:0] w_dec_l;
  logic [6:0] w_dec_r;

  assign w_ev_start = ~start_n & r_start_prev;
  assign w_ev_gl    = goal_left & ~r_gl_prev;
  assign w_ev_gr    = goal_right & ~r_gr_prev;
  // goal_left means the ball got past the left paddle: right player scores
  assign w_nxt_l    = r_score_l + {3'b000, w_ev_gr};
  assign w_nxt_r    = r_score_r + {3'b000, w_ev_gl};
  assign w_win_l    = (w_nxt_l == WIN);
  assign w_win_r    = (w_nxt_r == WIN);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_score_l    <= 4'd0;
      r_score_r    <= 4'd0;
      r_winner     <= 2'b00;
      r_cnt        <= '0;
      r_release    <= 1'b0;
      r_trst       <= 1'b0;
      r_start_prev <= 1'b1;
      r_gl_prev    <= 1'b0;
      r_gr_prev    <= 1'b0;
    end else begin
      r_start_prev <= start_n;
      r_gl_prev    <= goal_left;
      r_gr_prev    <= goal_right;
      r_release    <= 1'b0;
      unique case (r_state)
        S_IDLE, S_OVER: begin
          if (w_ev_start) begin
            r_score_l <= 4'd0;
            r_score_r <= 4'd0;
            r_winner  <= 2'b00;
            r_cnt     <= '0;
            r_trst    <= 1'b1;
            r_state   <= S_SERVE;
          end
        end
        S_SERVE: begin
          if (r_cnt == SD_LAST) begin
            r_release <= 1'b1;
            r_state   <= S_PLAY;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PLAY: begin
          if (w_ev_gl | w_ev_gr) begin
            r_score_l <= w_nxt_l;
            r_score_r <= w_nxt_r;
            if (w_win_l | w_win_r) begin
              r_winner <= {w_win_r, w_win_l};
              r_trst   <= 1'b0;
              r_state  <= S_OVER;
            end else begin
              r_cnt   <= '0;
              r_state <= S_SERVE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0011000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign w_dec_l = seg7(r_score_l);
  assign w_dec_r = seg7(r_score_r);

`ifdef MATCH_CTRL_BLINK_EN
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [BW-1:0] BH_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] r_bcnt;
  logic          r_blank;
  logic          w_blink;

  always_ff @(posedge clk) begin
    if (!reset || r_state != S_OVER) begin
      r_bcnt  <= '0;
      r_blank <= 1'b0;
    end else if (r_bcnt == BH_LAST) begin
      r_bcnt  <= '0;
      r_blank <= ~r_blank;
    end else begin
      r_bcnt <= r_bcnt + 1'b1;
    end
  end

  assign w_blink         = r_blank & (r_state == S_OVER);
  assign seg_score_left  = w_dec_l | {7{w_blink & r_winner[0]}};
  assign seg_score_right = w_dec_r | {7{w_blink & r_winner[1]}};
`else
  assign seg_score_left  = w_dec_l;
  assign seg_score_right = w_dec_r;
`endif

  assign ball_release = r_release;
  assign timer_reset  = r_trst;
  assign winner       = r_winner;

endmodule

// File: tb/tb_match_ctrl.sv
// Randomized and directed bench for match_ctrl against a behavioural match model.
// Blink expectations follow MATCH_CTRL_BLINK_EN when it is defined.
module tb_match_ctrl;

  localparam int W  = 3;
  localparam int SD = 4;
  localparam int BH = 5;

  logic       clk;
  logic       reset;
  logic       start_n;
  logic       goal_left;
  logic       goal_right;
  logic       ball_release;
  logic       timer_reset;
  logic [6:0] seg_score_left;
  logic [6:0] seg_score_right;
  logic [1:0] winner;

  match_ctrl #(
    .WIN_SCORE  (W),
    .SERVE_DELAY(SD),
    .BLINK_HALF (BH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_n        (start_n),
    .goal_left      (goal_left),
    .goal_right     (goal_right),
    .ball_release   (ball_release),
    .timer_reset    (timer_reset),
    .seg_score_left (seg_score_left),
    .seg_score_right(seg_score_right),
    .winner         (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] pat_tab [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
  };

  // phase: 0 idle, 1 serve, 2 play, 3 over
  int       m_ph;
  int       m_sl;
  int       m_sr;
  int       m_wait;
  int       m_over_k;
  bit       m_rel;
  bit       m_trst;
  bit [1:0] m_win;
  bit       m_ps;
  bit       m_pl;
  bit       m_pr;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mstep(input bit r, input bit s, input bit gl, input bit gr);
    bit es;
    bit el;
    bit er;
    if (!r) begin
      m_ph = 0; m_sl = 0; m_sr = 0; m_win = 2'b00;
      m_rel = 0; m_trst = 0; m_wait = 0; m_over_k = 0;
      m_ps = 1; m_pl = 0; m_pr = 0;
      return;
    end
    es = !s && m_ps;
    el = gl && !m_pl;
    er = gr && !m_pr;
    m_rel = 0;
    m_over_k++;
    case (m_ph)
      0, 3: if (es) begin
        m_sl = 0; m_sr = 0; m_win = 2'b00;
        m_wait = 0; m_ph = 1; m_trst = 1;
      end
      1: begin
        m_wait++;
        if (m_wait == SD) begin
          m_rel = 1;
          m_ph  = 2;
        end
      end
      2: if (el || er) begin
        m_sr += int'(el);
        m_sl += int'(er);
        if (m_sl == W || m_sr == W) begin
          m_ph = 3; m_trst = 0; m_over_k = 0;
          m_win = {m_sr == W, m_sl == W};
        end else begin
          m_ph = 1; m_wait = 0;
        end
      end
      default: ;
    endcase
    m_ps = s; m_pl = gl; m_pr = gr;
  endtask

  function automatic logic [6:0] exp_seg(input int sc, input bit mine);
`ifdef MATCH_CTRL_BLINK_EN
    if (m_ph == 3 && mine && ((m_over_k / BH) % 2 == 1))
      return 7'b1111111;
`endif
    return pat_tab[sc];
  endfunction

  task automatic cyc(input bit r, input bit s, input bit gl, input bit gr);
    reset = r; start_n = s; goal_left = gl; goal_right = gr;
    @(posedge clk);
    mstep(r, s, gl, gr);
    @(negedge clk);
    chk("release", ball_release, m_rel);
    chk("timer_reset", timer_reset, m_trst);
    chk("winner", winner, m_win);
    chk("seg_left", seg_score_left, exp_seg(m_sl, m_win[0]));
    chk("seg_right", seg_score_right, exp_seg(m_sr, m_win[1]));
  endtask

  bit rs;
  bit rg_l;
  bit rg_r;

  initial begin
    reset = 1'b0; start_n = 1'b1; goal_left = 1'b0; goal_right = 1'b0;
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("rst_seg_l", seg_score_left, 7'b1000000);
    chk("rst_seg_r", seg_score_right, 7'b1000000);
    repeat (10) cyc(1, 1, 0, 0);

    // start, serve, then goal_left held for 20 cycles
    cyc(1, 0, 0, 0);
    chk("trst_after_start", timer_reset, 1'b1);
    cyc(1, 1, 0, 0);
    repeat (3) cyc(1, 1, 0, 0);
    chk("serve_release", ball_release, 1'b1);
    cyc(1, 1, 0, 0);
    repeat (20) cyc(1, 1, 1, 0);
    chk("hold_once", seg_score_right, 7'b1111001);
    repeat (5) cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    chk("second_goal", seg_score_right, 7'b0100100);

    // reset in the middle of play
    repeat (5) cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 1);
    chk("pre_rst_left", seg_score_left, 7'b1111001);
    cyc(0, 1, 0, 0);
    chk("mid_rst_l", seg_score_left, 7'b1000000);
    chk("mid_rst_r", seg_score_right, 7'b1000000);
    repeat (8) cyc(1, 1, 0, 0);

    // simultaneous goals to a 3-3 draw
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      repeat (5) cyc(1, 1, 0, 0);
      cyc(1, 1, 1, 1);
    end
    chk("draw_winner", winner, 2'b11);
    chk("draw_seg_l", seg_score_left, 7'b0110000);
    chk("draw_trst", timer_reset, 1'b0);
    repeat (12) cyc(1, 1, 0, 0);

    // left wins 3-0 from OVER
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      repeat (5) cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 1);
    end
    chk("left_winner", winner, 2'b01);
    repeat (25) cyc(1, 1, 0, 0);
    chk("loser_seg_r", seg_score_right, 7'b1000000);

    rg_l = 0;
    rg_r = 0;
    for (int i = 0; i < 4000; i++) begin
      rs = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 5) == 0) rg_l = ~rg_l;
      if ($urandom_range(0, 5) == 0) rg_r = ~rg_r;
      cyc($urandom_range(0, 399) != 0, rs, rg_l, rg_r);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
